// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one asynchronous 16-bit SRAM between two requesters. The SRAM has an
// 18-bit word address and active-low CE/OE/WE strobes.
//   Port A: instruction fetch, read-only.
//   Port B: data path, read/write.
// B has fixed priority over A. After STARVE_LIMIT consecutive B grants made
// while A was waiting, A wins the next arbitration.
//
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   a_req, a_addr              port A read request and word address
//   a_ack, a_rdata             port A completion pulse and read data
//   b_req, b_we                port B request and direction (1 = write)
//   b_addr, b_wdata            port B word address and write data
//   b_ack, b_rdata             port B completion pulse and read data
//   physical_mem_bus           SRAM data bus (tri-state)
//   physical_mem_addr          SRAM address (holds its last value when idle)
//   physical_mem_read          SRAM OE, active-low
//   physical_mem_write         SRAM WE, active-low
//   physical_mem_enable        SRAM CE, active-low
//
// Optional: define ARB_STATS_EN to add the conflict_count and starve_grants
// statistics outputs.

module sram_port_arbiter #(
   parameter int READ_WAIT    = 1,
   parameter int WRITE_WIDTH  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [17:0] a_addr,
   output logic        a_ack,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [17:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_ack,
   output logic [15:0] b_rdata,
   inout  wire  [15:0] physical_mem_bus,
   output logic [17:0] physical_mem_addr,
   output logic        physical_mem_read,
   output logic        physical_mem_write,
   output logic        physical_mem_enable
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] conflict_count,
   output logic [15:0] starve_grants
`endif
);

   localparam logic [3:0] RD_LAST = 4'(READ_WAIT);
   localparam logic [3:0] WR_LAST = 4'(WRITE_WIDTH - 1);
   localparam logic [3:0] S_LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACCESS,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      DONE
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  starve_cnt;
   logic        grant_b;
   logic        bus_oe;
   logic [15:0] wdata_q;
   logic        a_forced;
   logic        pick_b;

   // B wins unless A is also waiting and has hit the starvation limit.
   always_comb begin
      a_forced = a_req && (starve_cnt == S_LIMIT);
      pick_b   = b_req && !a_forced;
   end

   assign physical_mem_bus = bus_oe ? wdata_q : 'z;

   // Acks are set on the edge entering DONE, so they are high during DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         starve_cnt          <= '0;
         grant_b             <= 1'b0;
         bus_oe              <= 1'b0;
         wdata_q             <= '0;
         physical_mem_addr   <= '0;
         physical_mem_read   <= 1'b1;
         physical_mem_write  <= 1'b1;
         physical_mem_enable <= 1'b1;
         a_ack               <= 1'b0;
         b_ack               <= 1'b0;
         a_rdata             <= '0;
         b_rdata             <= '0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (pick_b) begin
                  grant_b             <= 1'b1;
                  physical_mem_addr   <= b_addr;
                  wdata_q             <= b_wdata;
                  physical_mem_enable <= 1'b0;
                  // When a_req is high here, starve_cnt is below the limit,
                  // so the increment cannot overshoot.
                  starve_cnt <= a_req ? starve_cnt + 4'd1 : '0;
                  if (b_we) begin
                     bus_oe <= 1'b1;
                     state  <= WR_SETUP;
                  end else begin
                     physical_mem_read <= 1'b0;
                     state             <= RD_ACCESS;
                  end
               end else if (a_req) begin
                  grant_b             <= 1'b0;
                  physical_mem_addr   <= a_addr;
                  physical_mem_enable <= 1'b0;
                  physical_mem_read   <= 1'b0;
                  starve_cnt          <= '0;
                  state               <= RD_ACCESS;
               end else begin
                  starve_cnt <= '0;
               end
            end
            RD_ACCESS: begin
               if (cnt == RD_LAST) begin
                  if (grant_b) begin
                     b_rdata <= physical_mem_bus;
                     b_ack   <= 1'b1;
                  end else begin
                     a_rdata <= physical_mem_bus;
                     a_ack   <= 1'b1;
                  end
                  physical_mem_read   <= 1'b1;
                  physical_mem_enable <= 1'b1;
                  state               <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WR_SETUP: begin
               physical_mem_write <= 1'b0;
               state              <= WR_STROBE;
            end
            WR_STROBE: begin
               if (cnt == WR_LAST) begin
                  physical_mem_write <= 1'b1;
                  state              <= WR_HOLD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WR_HOLD: begin
               bus_oe              <= 1'b0;
               physical_mem_enable <= 1'b1;
               b_ack               <= 1'b1;
               state               <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         conflict_count <= '0;
         starve_grants  <= '0;
      end else if (state == IDLE) begin
         if (a_req && b_req) begin
            conflict_count <= conflict_count + 16'd1;
         end
         if (a_forced && b_req) begin
            starve_grants <= starve_grants + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Self-checking bench for sram_port_arbiter. It contains:
//   - an SRAM model on the physical pins, with a pull-up on the data bus;
//   - table-driven single-transaction vectors;
//   - hand-written reset, reset-abort and contention sequences;
//   - a randomized phase checked against a transaction-level arbitration model.

module tb_sram_port_arbiter;

   localparam int RW = 1;
   localparam int WW = 1;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, b_we;
   logic [17:0] a_addr, b_addr;
   logic [15:0] b_wdata;
   logic        a_ack, b_ack;
   logic [15:0] a_rdata, b_rdata;
   wire  [15:0] physical_mem_bus;
   logic [17:0] physical_mem_addr;
   logic        physical_mem_read, physical_mem_write, physical_mem_enable;
`ifdef ARB_STATS_EN
   logic [15:0] conflict_count, starve_grants;
`endif

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .READ_WAIT   (RW),
      .WRITE_WIDTH (WW),
      .STARVE_LIMIT(SL)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .a_req              (a_req),
      .a_addr             (a_addr),
      .a_ack              (a_ack),
      .a_rdata            (a_rdata),
      .b_req              (b_req),
      .b_we               (b_we),
      .b_addr             (b_addr),
      .b_wdata            (b_wdata),
      .b_ack              (b_ack),
      .b_rdata            (b_rdata),
      .physical_mem_bus   (physical_mem_bus),
      .physical_mem_addr  (physical_mem_addr),
      .physical_mem_read  (physical_mem_read),
      .physical_mem_write (physical_mem_write),
      .physical_mem_enable(physical_mem_enable)
`ifdef ARB_STATS_EN
      ,
      .conflict_count     (conflict_count),
      .starve_grants      (starve_grants)
`endif
   );

   // SRAM model: drives read data while CE and OE are low, and stores the bus
   // on any edge where CE and WE are low. An undriven bus reads as all ones.
   pullup (physical_mem_bus);

   logic [15:0] sram_mem [0:262143];
   logic [15:0] mdl_mem  [0:262143];
   logic [15:0] sram_rd;

   function automatic logic [15:0] dflt(input logic [17:0] a);
      return a[15:0] ^ 16'hA5C3;
   endfunction

   assign physical_mem_bus = (!physical_mem_read && !physical_mem_enable) ? sram_rd : 'z;

   always @(negedge clk) sram_rd <= sram_mem[physical_mem_addr];

   always @(posedge clk) begin
      if (!physical_mem_write && !physical_mem_enable) begin
         sram_mem[physical_mem_addr] <= physical_mem_bus;
      end
   end

   // Pin-protocol monitor: OE and WE must never be low together.
   logic mon_en = 1'b0;
   int   proto_err = 0;
   always @(negedge clk) begin
      if (mon_en && rst && !physical_mem_read && !physical_mem_write) begin
         proto_err <= proto_err + 1;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Enter with inputs idle; leaves the bench in a free IDLE cycle.
   task automatic do_reset();
      a_req = 1'b0;
      b_req = 1'b0;
      b_we  = 1'b0;
      rst   = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   typedef struct {
      logic        is_b;
      logic        we;
      logic [17:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] rdata;
      logic [7:0]  rd_mask;
      logic [7:0]  wr_mask;
      logic [7:0]  dv_mask;
   } vec_t;

   vec_t        vecs [10];
   logic [15:0] exp_ard, exp_brd;

   task automatic run_vec(input int idx, input vec_t v);
      logic [7:0] rd_m, wr_m, dv_m;
      int         lat;
      logic       wrong;
      rd_m    = '0;
      wr_m    = '0;
      dv_m    = '0;
      lat     = -1;
      wrong   = 1'b0;
      a_addr  = v.addr;
      b_addr  = v.addr;
      b_we    = v.we;
      b_wdata = v.wdata;
      a_req   = !v.is_b;
      b_req   = v.is_b;
      for (int c = 0; c < 8 && lat < 0; c++) begin
         if (c > 0) step();
         rd_m[c] = !physical_mem_read;
         wr_m[c] = !physical_mem_write;
         dv_m[c] = (physical_mem_bus == v.wdata);
         if (a_ack || b_ack) begin
            lat   = c;
            wrong = v.is_b ? a_ack : b_ack;
            a_req = 1'b0;
            b_req = 1'b0;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("vec%0d wrong_port_ack", idx), 32'(wrong), 32'd0);
      check($sformatf("vec%0d oe_cycles", idx), 32'(rd_m), 32'(v.rd_mask));
      check($sformatf("vec%0d we_cycles", idx), 32'(wr_m), 32'(v.wr_mask));
      if (v.we) begin
         check($sformatf("vec%0d bus_drive_cycles", idx), 32'(dv_m), 32'(v.dv_mask));
         check($sformatf("vec%0d sram_contents", idx), 32'(sram_mem[v.addr]), 32'(v.wdata));
      end else if (v.is_b) begin
         exp_brd = v.rdata;
      end else begin
         exp_ard = v.rdata;
      end
      check($sformatf("vec%0d a_rdata", idx), 32'(a_rdata), 32'(exp_ard));
      check($sformatf("vec%0d b_rdata", idx), 32'(b_rdata), 32'(exp_brd));
      step();
      step();
   endtask

   // Random-phase state
   int          scnt, free_cyc, ack_cyc, a_cool, b_cool, m_conf, m_starve;
   logic        busy, win_b, won, a_pend, b_pend, t_we;
   logic [17:0] t_addr;
   logic [15:0] t_wdata;
   logic [1:0]  exp_acks;

   function automatic logic [17:0] rand_addr();
      logic [17:0] r;
      r = 18'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = r | 18'h3FFF0;
      return r;
   endfunction

   // Contention-phase state
   int       grants, run_b, max_run;
   logic [9:0] seq;
   int       acks_seen;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 262144; i++) sram_mem[i] <= dflt(18'(i));
      sram_mem[18'h00010] <= 16'h1234;

      //                 is_b  we   addr       wdata     lat rdata    oe        we        drive
      vecs[0] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 3, 16'h1234, 8'h06, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 4, 16'h0000, 8'h00, 8'h04, 8'h0E};
      vecs[2] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 3, 16'hBEEF, 8'h06, 8'h00, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 3, 16'hBEEF, 8'h06, 8'h00, 8'h00};
      vecs[4] = '{1'b1, 1'b1, 18'h00000, 16'h0000, 4, 16'h0000, 8'h00, 8'h04, 8'h0E};
      vecs[5] = '{1'b0, 1'b0, 18'h00000, 16'h0000, 3, 16'h0000, 8'h06, 8'h00, 8'h00};
      vecs[6] = '{1'b1, 1'b0, 18'h00010, 16'h0000, 3, 16'h1234, 8'h06, 8'h00, 8'h00};
      vecs[7] = '{1'b1, 1'b1, 18'h12345, 16'h5A5A, 4, 16'h0000, 8'h00, 8'h04, 8'h0E};
      vecs[8] = '{1'b0, 1'b0, 18'h12345, 16'h0000, 3, 16'h5A5A, 8'h06, 8'h00, 8'h00};
      vecs[9] = '{1'b1, 1'b0, 18'h00020, 16'h0000, 3, 16'hA5E3, 8'h06, 8'h00, 8'h00};

      a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
      a_addr = '0; b_addr = '0; b_wdata = '0;

      // Reset state
      rst = 1'b0;
      step();
      step();
      check("rst oe_n", 32'(physical_mem_read), 32'd1);
      check("rst we_n", 32'(physical_mem_write), 32'd1);
      check("rst ce_n", 32'(physical_mem_enable), 32'd1);
      check("rst bus_released", 32'(physical_mem_bus), 32'hFFFF);
      check("rst addr", 32'(physical_mem_addr), 32'd0);
      check("rst acks", 32'({a_ack, b_ack}), 32'd0);
      check("rst a_rdata", 32'(a_rdata), 32'd0);
      check("rst b_rdata", 32'(b_rdata), 32'd0);
      rst = 1'b1;
      mon_en = 1'b1;
      step();
      exp_ard = '0;
      exp_brd = '0;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset while WE is low aborts the write, with no ack.
      b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00100; b_wdata = 16'hC0DE;
      step();
      step();
      check("abort we_low_before_reset", 32'(physical_mem_write), 32'd0);
      rst = 1'b0;
      b_req = 1'b0;
      step();
      check("abort we_n", 32'(physical_mem_write), 32'd1);
      check("abort ce_n", 32'(physical_mem_enable), 32'd1);
      check("abort bus_released", 32'(physical_mem_bus), 32'hFFFF);
      rst = 1'b1;
      acks_seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (a_ack || b_ack) acks_seen++;
         step();
      end
      check("abort no_ack", 32'(acks_seen), 32'd0);
      exp_ard = '0;
      exp_brd = '0;
      check("abort b_rdata_cleared", 32'(b_rdata), 32'd0);
      run_vec(10, vecs[6]);

      // Contention: both requesters held high, B doing reads.
      do_reset();
      a_req = 1'b1; a_addr = 18'h00010;
      b_req = 1'b1; b_we = 1'b0; b_addr = 18'h3FFFF;
      grants = 0; run_b = 0; max_run = 0; seq = '0;
      for (int c = 0; c < 200 && grants < 10; c++) begin
         if (c > 0) step();
         if (a_ack || b_ack) begin
            seq[grants] = b_ack;
            grants++;
            if (b_ack) begin
               run_b++;
               check("cont b_rdata", 32'(b_rdata), 32'hBEEF);
            end else begin
               run_b = 0;
               check("cont a_rdata", 32'(a_rdata), 32'h1234);
            end
            if (run_b > max_run) max_run = run_b;
            if (grants == 10) begin
               a_req = 1'b0;
               b_req = 1'b0;
            end
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      step();
      step();
      check("cont grant_count", 32'(grants), 32'd10);
      check("cont grant_order", 32'(seq), 32'b0111101111);
      check("cont max_b_streak", 32'(max_run <= SL), 32'd1);
`ifdef ARB_STATS_EN
      check("cont conflict_count", 32'(conflict_count), 32'd10);
      check("cont starve_grants", 32'(starve_grants), 32'd2);
`endif

      // Randomized traffic against the transaction-level model.
      do_reset();
      for (int i = 0; i < 262144; i++) mdl_mem[i] = sram_mem[i];
      exp_ard = '0; exp_brd = '0;
      scnt = 0; busy = 1'b0; win_b = 1'b0; free_cyc = 0; ack_cyc = 0;
      m_conf = 0; m_starve = 0;
      a_pend = 1'b0; b_pend = 1'b0; a_cool = 0; b_cool = 0;
      t_addr = '0; t_we = 1'b0; t_wdata = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc > 0) step();
         exp_acks = 2'b00;
         if (busy && cyc == ack_cyc) exp_acks = win_b ? 2'b01 : 2'b10;
         check($sformatf("rand ack{a,b} cyc%0d", cyc), 32'({a_ack, b_ack}), 32'(exp_acks));
         if (busy && cyc == ack_cyc) begin
            if (win_b) begin
               if (t_we) begin
                  mdl_mem[t_addr] = t_wdata;
                  check("rand sram_write", 32'(sram_mem[t_addr]), 32'(t_wdata));
               end else begin
                  exp_brd = mdl_mem[t_addr];
                  check("rand b_rdata", 32'(b_rdata), 32'(exp_brd));
               end
               b_req = 1'b0; b_pend = 1'b0; b_cool = cyc + 2;
            end else begin
               exp_ard = mdl_mem[t_addr];
               check("rand a_rdata", 32'(a_rdata), 32'(exp_ard));
               a_req = 1'b0; a_pend = 1'b0; a_cool = cyc + 2;
            end
            busy = 1'b0;
            free_cyc = cyc + 1;
         end
         if (!a_pend && cyc >= a_cool && $urandom_range(0, 2) == 0) begin
            a_pend = 1'b1; a_req = 1'b1; a_addr = rand_addr();
         end
         if (!b_pend && cyc >= b_cool && $urandom_range(0, 3) != 0) begin
            b_pend = 1'b1; b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
            b_addr = rand_addr(); b_wdata = 16'($urandom);
         end
         if (!busy && cyc >= free_cyc) begin
            won = 1'b0;
            if (a_req && b_req) m_conf++;
            if (b_req && !(a_req && scnt == SL)) begin
               won = 1'b1; win_b = 1'b1;
               t_addr = b_addr; t_we = b_we; t_wdata = b_wdata;
               scnt = a_req ? ((scnt < SL) ? scnt + 1 : SL) : 0;
            end else if (a_req) begin
               won = 1'b1; win_b = 1'b0;
               t_addr = a_addr; t_we = 1'b0;
               if (b_req) m_starve++;
               scnt = 0;
            end else begin
               scnt = 0;
            end
            if (won) begin
               busy = 1'b1;
               ack_cyc = cyc + (t_we ? WW + 3 : RW + 2);
            end
         end
      end
      check("rand final a_rdata", 32'(a_rdata), 32'(exp_ard));
      check("rand final b_rdata", 32'(b_rdata), 32'(exp_brd));
`ifdef ARB_STATS_EN
      check("rand conflict_count", 32'(conflict_count), 32'(16'(m_conf)));
      check("rand starve_grants", 32'(starve_grants), 32'(16'(m_starve)));
`endif
      a_req = 1'b0;
      b_req = 1'b0;
      step();
      step();
      check("oe_we_never_both_low", 32'(proto_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM (18-bit address, active-low strobes) between two requesters.
- Port A is the CPU instruction-fetch path and is read-only; port B is the CPU data path and does read/write.
- Sits between the virtual-memory/address-mapping layer and the physical memory pins. It sequences SRAM read and write timing and arbitrates by fixed priority (B over A) with an anti-starvation override for A.

Parameters:
- READ_WAIT, 1: extra ACCESS cycles before read data is sampled (0..15).
- WRITE_WIDTH, 1: cycles physical_mem_write is held low (1..15).
- STARVE_LIMIT, 4: consecutive B grants while A is waiting, after which A wins the next arbitration (1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- a_req  in  1  port A read request.
- a_addr  in  18  port A word address.
- a_ack  out  1  one-cycle completion pulse for port A.
- a_rdata  out  16  port A read data.
- b_req  in  1  port B request.
- b_we  in  1  port B direction: 1 = write, 0 = read.
- b_addr  in  18  port B word address.
- b_wdata  in  16  port B write data.
- b_ack  out  1  one-cycle completion pulse for port B.
- b_rdata  out  16  port B read data.
- physical_mem_bus  inout  16  SRAM data bus.
- physical_mem_addr  out  18  SRAM address.
- physical_mem_read  out  1  SRAM OE, active-low.
- physical_mem_write  out  1  SRAM WE, active-low.
- physical_mem_enable  out  1  SRAM CE, active-low.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - physical_mem_read, physical_mem_write and physical_mem_enable are 1; physical_mem_bus is Z; physical_mem_addr is 0.
  - a_ack and b_ack are 0; a_rdata and b_rdata are 0; starvation counter is 0.
  - Reset mid-access aborts immediately: strobes go high and the bus is released on the next edge, and no ack is issued.
- Handshake:
  - A requester holds req with stable addr/we/wdata until it sees ack.
  - Addr, we and wdata are latched at grant.
  - ack is a single-cycle pulse. rdata is valid in the ack cycle and held until that port's next ack.
  - req must drop in the cycle after ack, otherwise it counts as a new request.
  - Dropping req after grant does not abort the access; ack is still issued.
- States: IDLE, RD_ACCESS, WR_SETUP, WR_STROBE, WR_HOLD, DONE.
- IDLE:
  - All strobes high, bus Z.
  - Arbitration:
    - b_req alone: grant B.
    - a_req alone: grant A.
    - Both: grant B unless starve_cnt == STARVE_LIMIT, in which case grant A.
  - Next state: RD_ACCESS for A or a B read; WR_SETUP for a B write.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each B grant made while a_req is high.
  - Clears on any A grant, and on any IDLE cycle with a_req low.
- RD_ACCESS:
  - Lasts READ_WAIT+1 cycles.
  - physical_mem_enable=0, physical_mem_read=0, physical_mem_addr=latched address.
  - On the final cycle's closing edge, physical_mem_bus is registered into the granted port's rdata; next state is DONE.
- Write sequence:
  - WR_SETUP, 1 cycle: enable=0, bus driven with wdata, write=1.
  - WR_STROBE, WRITE_WIDTH cycles: write=0.
  - WR_HOLD, 1 cycle: write=1, bus still driven.
  - Then DONE.
- DONE:
  - 1 cycle; strobes high, bus Z.
  - Granted port's ack=1; next state IDLE.
- Latency from req first seen in IDLE (cycle 0) to ack:
  - Read: READ_WAIT+2 cycles after cycle 0 (defaults: ack in cycle 3).
  - Write: WRITE_WIDTH+3 (defaults: ack in cycle 4).
- Bus rules:
  - physical_mem_bus is never driven while physical_mem_read is 0.
  - read and write are never 0 in the same cycle.
- physical_mem_addr holds its last value when idle.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds output conflict_count[15:0], a wrapping counter of IDLE cycles in which a_req and b_req are both high.
  - Adds output starve_grants[15:0], a wrapping counter of A grants forced by the starvation rule.
  - Both counters reset to 0.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset with rst=0 for 2 cycles, bus pulled 16'hFFFF → strobes 1/1/1, bus Z, acks 0, rdata 0.
- A read of addr 18'h00010, SRAM model returns 16'h1234 → physical_mem_read=0 in cycles 1-2, a_ack in cycle 3, a_rdata=16'h1234.
- B write of 16'hBEEF to 18'h3FFFF → bus driven in cycles 1-3, physical_mem_write=0 only in cycle 2, b_ack in cycle 4; SRAM model holds 16'hBEEF at 18'h3FFFF.
- a_req and b_req held high continuously with B reads → grant order B,B,B,B,A,B,B,B,B,A; A is never waiting more than 5 grants.
- rst=0 asserted during WR_STROBE → next edge write=1, bus Z, no b_ack; fresh B read after reset completes normally.
- With ARB_STATS_EN and the contention scenario over 10 grants → starve_grants=2; conflict_count equals the number of both-requesting IDLE cycles.
